uart_tx_arbiter: RTL and testbench

Shares the single uart_tx serializer among NUM_SRC independent byte-stream requesters, such as a status reporter, a debug dump and a CV-result printer. Sources present whole messages: byte streams delimited by a last flag. The arbiter grants round-robin at message granularity, so messages never interleave on the wire. It sits between the requester logic and the uart_tx instance and drives that instance's tx_data / tx_data_valid / tx_data_ready handshake.

---
 rtl/uart_pkg.sv | 18 +
 rtl/rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM encoding and
// clock/baud figures.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StXfer  = 2'd1,
    StDrain = 2'd2
  } arb_state_e;

  localparam int unsigned CLK_FREQ_MHZ    = 27;
  localparam int unsigned BAUD_RATE       = 115200;
  localparam int unsigned DEF_TIMEOUT_CYC = 2_700_000;
  // Clock cycles per 10-bit UART frame (start + 8 data + stop), rounded.
  localparam int unsigned BYTE_CYC =
      (10 * CLK_FREQ_MHZ * 1_000_000 + BAUD_RATE / 2) / BAUD_RATE;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request bit at or after ptr_i,
// wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  int unsigned cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = 0;
    // Scan farthest offset first so the nearest request overwrites it.
    for (int unsigned i = N; i > 0; i--) begin
      cand = (32'(ptr_i) + i - 1) % N;
      if (req_i[W'(cand)]) begin
        idx_o   = W'(cand);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx among NUM_SRC
// byte-stream sources, with a one-byte output register and a stall timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned SRC_W       = 2,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned CNT_W       = 22
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_data_valid,
  input  logic                 tx_data_ready,
  output logic [SRC_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  arb_state_e       state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tout_q, tout_d;

  logic [SRC_W-1:0] pick_idx;
  logic             pick_found;
  logic             grant_ready, accept, stall, tout_hit;
  logic [SRC_W-1:0] grant_next;

  rr_pick #(
    .N (NUM_SRC),
    .W (SRC_W)
  ) u_rr_pick (
    .req_i   (src_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Ready is combinational on tx_data_ready so back-to-back bytes need no bubble.
  assign grant_ready = (state_q == StXfer) && (!tx_valid_q || tx_data_ready);
  assign accept      = grant_ready && src_valid[grant_q];
  assign stall       = !src_valid[grant_q] && !tx_valid_q;
  assign tout_hit    = (TIMEOUT_CYC != 0) && stall &&
                       (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign grant_next  = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tout_d     = 1'b0;

    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = src_data[{grant_q, 3'b000} +: 8];
    end else if (tx_data_ready) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        // An accept on the would-be timeout cycle takes precedence.
        if (accept) begin
          cnt_d = '0;
          if (src_last[grant_q]) state_d = StDrain;
        end else if (tout_hit) begin
          cnt_d    = '0;
          tout_d   = 1'b1;
          state_d  = StIdle;
          rr_ptr_d = grant_next;
        end else if (stall) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (!tx_valid_q || tx_data_ready) begin
          state_d  = StIdle;
          rr_ptr_d = grant_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tout_q     <= tout_d;
    end
  end

  always_comb begin
    src_ready          = '0;
    src_ready[grant_q] = grant_ready;
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != StIdle);
  assign timeout_err   = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-source message queues drive the
// sources, a monitor checks every byte handed to uart_tx against expectations.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned NS = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [8*NS-1:0] src_data;
  logic [NS-1:0]   src_valid, src_last, src_ready;
  logic [7:0]      tx_data;
  logic            tx_data_valid, tx_data_ready;
  logic [1:0]      grant_id;
  logic            busy, timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_SRC     (NS),
    .SRC_W       (2),
    .TIMEOUT_CYC (8),
    .CNT_W       (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_data      (src_data),
    .src_valid     (src_valid),
    .src_last      (src_last),
    .src_ready     (src_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  int total = 0;
  int bad   = 0;
  logic [8:0] sq [NS][$];   // {last, data} per source
  logic [9:0] exp_q [$];    // {grant, data} in expected wire order
  int acc_cnt [NS];
  int tout_seen  = 0;
  int ready_mode = 0;
  int rdy_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NS; i++) begin
      if (sq[i].size() > 0) begin
        src_valid[i]     = 1'b1;
        src_data[8*i+:8] = sq[i][0][7:0];
        src_last[i]      = sq[i][0][8];
      end else begin
        src_valid[i]     = 1'b0;
        src_data[8*i+:8] = 8'h00;
        src_last[i]      = 1'b0;
      end
    end
  endtask

  task automatic drive_ready();
    if (ready_mode == 0) begin
      tx_data_ready = 1'b1;
    end else begin
      rdy_cnt       = (rdy_cnt == int'(BYTE_CYC) - 1) ? 0 : rdy_cnt + 1;
      tx_data_ready = (rdy_cnt == 0);
    end
  endtask

  // One clock: sample handshakes before the edge, update sources after it.
  task automatic tick();
    logic [NS-1:0] acc;
    @(negedge clk);
    acc = src_valid & src_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (acc[i]) begin
        void'(sq[i].pop_front());
        acc_cnt[i]++;
      end
    end
    refresh();
    drive_ready();
  endtask

  task automatic src_push(input int s, input logic [7:0] d, input logic last);
    sq[s].push_back({last, d});
  endtask

  task automatic exp_push(input int g, input logic [7:0] d);
    logic [1:0] gg;
    gg = g[1:0];
    exp_q.push_back({gg, d});
  endtask

  function automatic bit sq_pending();
    bit p = 1'b0;
    for (int i = 0; i < NS; i++) if (sq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0 || sq_pending()) && n < budget) begin
      tick();
      n++;
    end
    chk(name, (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_src_ready"}, 32'(src_ready), 0);
    chk({tag, "_tx_data"}, 32'(tx_data), 0);
    chk({tag, "_tx_valid"}, 32'(tx_data_valid), 0);
    chk({tag, "_grant"}, 32'(grant_id), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_tout"}, 32'(timeout_err), 0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    for (int i = 0; i < NS; i++) sq[i].delete();
    exp_q.delete();
    refresh();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every byte handed to uart_tx is checked against the scoreboard.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (timeout_err) tout_seen++;
        if (src_ready != '0) chk("ready_onehot", 32'(src_ready), 32'(1) << grant_id);
        if (tx_data_valid && tx_data_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected: got %0h want none", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", 32'(tx_data), 32'(e[7:0]));
            chk("tx_grant", 32'(grant_id), 32'(e[9:8]));
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ok_b [4];
    int n;
    ok_b = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    for (int i = 0; i < NS; i++) acc_cnt[i] = 0;
    rst_n = 1'b0;
    src_valid = '0;
    src_data = '0;
    src_last = '0;
    tx_data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Source 1 alone, "OK\r\n"; tx_data_valid rises two cycles after src_valid.
    for (int k = 0; k < 4; k++) begin
      src_push(1, ok_b[k], k == 3);
      exp_push(1, ok_b[k]);
    end
    refresh();
    tick();
    chk("t1_grant", 32'(grant_id), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ready", 32'(src_ready), 32'h2);
    chk("t1_valid_c1", 32'(tx_data_valid), 0);
    tick();
    chk("t1_valid_c2", 32'(tx_data_valid), 1);
    chk("t1_first", 32'(tx_data), 32'h4F);
    wait_done(50, "t1_done");
    chk("t1_idle", 32'(busy), 0);

    // Sources 0 and 2 from reset, two 3-byte messages each: order 0,2,0,2.
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      src_push(0, 8'hA0 + 8'(k), k == 2);
      src_push(2, 8'hC0 + 8'(k), k == 2);
    end
    for (int k = 0; k < 3; k++) begin
      src_push(0, 8'hB0 + 8'(k), k == 2);
      src_push(2, 8'hD0 + 8'(k), k == 2);
    end
    for (int k = 0; k < 3; k++) exp_push(0, 8'hA0 + 8'(k));
    for (int k = 0; k < 3; k++) exp_push(2, 8'hC0 + 8'(k));
    for (int k = 0; k < 3; k++) exp_push(0, 8'hB0 + 8'(k));
    for (int k = 0; k < 3; k++) exp_push(2, 8'hD0 + 8'(k));
    refresh();
    wait_done(200, "t2_done");

    // 16-byte message from source 1 against a baud-rate paced uart_tx.
    ready_mode = 1;
    rdy_cnt = 0;
    acc_cnt[1] = 0;
    for (int k = 0; k < 16; k++) begin
      src_push(1, 8'h30 + 8'(k), k == 15);
      exp_push(1, 8'h30 + 8'(k));
    end
    refresh();
    wait_done(16 * int'(BYTE_CYC) + 200, "t3_done");
    chk("t3_accepts", 32'(acc_cnt[1]), 16);
    ready_mode = 0;
    tx_data_ready = 1'b1;

    // Source 3 stalls after one byte; source 0 queues up meanwhile.
    tout_seen = 0;
    src_push(3, 8'h55, 1'b0);
    exp_push(3, 8'h55);
    refresh();
    n = 0;
    while (!tx_data_valid && n < 20) begin
      tick();
      n++;
    end
    chk("t4_loaded", 32'(tx_data_valid), 1);
    src_push(0, 8'hE0, 1'b0);
    src_push(0, 8'hE1, 1'b1);
    exp_push(0, 8'hE0);
    exp_push(0, 8'hE1);
    refresh();
    tick();
    chk("t4_empty", 32'(tx_data_valid), 0);
    n = 0;
    while (!timeout_err && n < 20) begin
      tick();
      n++;
    end
    chk("t4_stall_cycles", 32'(n), 8);
    wait_done(100, "t4_done");
    chk("t4_tout_pulses", 32'(tout_seen), 1);

    // Move rr_ptr to 3, then reset in the middle of a source 1 message.
    src_push(2, 8'h77, 1'b1);
    exp_push(2, 8'h77);
    refresh();
    wait_done(50, "t5_pre");
    for (int k = 0; k < 6; k++) begin
      src_push(1, 8'h60 + 8'(k), k == 5);
      exp_push(1, 8'h60 + 8'(k));
    end
    refresh();
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t5_async");
    for (int i = 0; i < NS; i++) sq[i].delete();
    exp_q.delete();
    refresh();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    src_push(1, 8'h81, 1'b0);
    src_push(1, 8'h82, 1'b1);
    src_push(3, 8'h91, 1'b1);
    exp_push(1, 8'h81);
    exp_push(1, 8'h82);
    exp_push(3, 8'h91);
    refresh();
    wait_done(100, "t5_done");

    // Single-byte messages from all sources: grants 0,1,2,3 then wrap to 0.
    src_push(0, 8'hA0, 1'b1);
    src_push(1, 8'hA1, 1'b1);
    src_push(2, 8'hA2, 1'b1);
    src_push(3, 8'hA3, 1'b1);
    src_push(0, 8'hB0, 1'b1);
    exp_push(0, 8'hA0);
    exp_push(1, 8'hA1);
    exp_push(2, 8'hA2);
    exp_push(3, 8'hA3);
    exp_push(0, 8'hB0);
    refresh();
    wait_done(100, "t6_done");
    chk("t6_last_grant", 32'(grant_id), 0);
    chk("final_sb_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
